mem_word_loader: RTL and testbench

//   Multi-cycle load sequencer: reads NUM_BYTES consecutive bytes from the byte-wide

---
 rtl/mem_word_loader.sv | 122 ++++++++++++
 tb/tb_mem_word_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_word_loader.sv
// mem_word_loader: byte-serial little-endian word load sequencer.
// Optional CALC cycle (BaseAddr+Offset) under WORD_LOADER_OFFSET_EN.
module mem_word_loader #(
  parameter int ADDR_W    = 16,
  parameter int NUM_BYTES = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [ADDR_W-1:0]      BaseAddr,
  input  logic [7:0]             Offset,
  input  logic [7:0]             Mem_Data,
  output logic [ADDR_W-1:0]      Mem_Addr,
  output logic                   Mem_CS,
  output logic                   Mem_WR,
  output logic                   Busy,
  output logic                   Done,
  output logic [8*NUM_BYTES-1:0] DataOut,
  output logic [ADDR_W-1:0]      EndAddr
);

  localparam int CW = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);
  localparam int DW = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_READ,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   data_q, data_d;
  logic [ADDR_W-1:0] end_q, end_d;

`ifndef WORD_LOADER_OFFSET_EN
  logic unused_offset;
  assign unused_offset = ^Offset;
`endif

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      end_q   <= end_d;
    end
  end

  // Next-state, byte assembly and result capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    end_d   = end_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d = BaseAddr;
          cnt_d  = '0;
          acc_d  = '0;
`ifdef WORD_LOADER_OFFSET_EN
          state_d = S_CALC;
`else
          state_d = S_READ;
`endif
        end
      end
`ifdef WORD_LOADER_OFFSET_EN
      S_CALC: begin
        addr_d  = addr_q + ADDR_W'(Offset);
        state_d = S_READ;
      end
`endif
      S_READ: begin
        acc_d[{cnt_q, 3'b000} +: 8] = Mem_Data;
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          data_d  = acc_d;
          end_d   = addr_q + ADDR_W'(1);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory strobes and status decoded from state.
  always_comb begin
    Busy     = (state_q == S_READ) || (state_q == S_CALC);
    Done     = (state_q == S_DONE);
    Mem_CS   = (state_q != S_READ);
    Mem_WR   = 1'b0;
    Mem_Addr = (state_q == S_READ) ? addr_q : '0;
    DataOut  = data_q;
    EndAddr  = end_q;
  end

endmodule

// File: tb/tb_mem_word_loader.sv
// tb_mem_word_loader: scoreboard bench for mem_word_loader.
// Expected words come from a byte-array memory model.
module tb_mem_word_loader;

  localparam int NB = 4;
`ifdef WORD_LOADER_OFFSET_EN
  localparam int RS = 2;
`else
  localparam int RS = 1;
`endif
  localparam int LAT = RS + NB;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [7:0]  Offset;
  logic [7:0]  Mem_Data;
  logic [15:0] Mem_Addr;
  logic        Mem_CS;
  logic        Mem_WR;
  logic        Busy;
  logic        Done;
  logic [31:0] DataOut;
  logic [15:0] EndAddr;

  mem_word_loader #(.ADDR_W(16), .NUM_BYTES(NB)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .BaseAddr(BaseAddr),
    .Offset(Offset),
    .Mem_Data(Mem_Data),
    .Mem_Addr(Mem_Addr),
    .Mem_CS(Mem_CS),
    .Mem_WR(Mem_WR),
    .Busy(Busy),
    .Done(Done),
    .DataOut(DataOut),
    .EndAddr(EndAddr)
  );

  always #5 Clock = ~Clock;

  logic [7:0] mem [0:65535];
  assign Mem_Data = mem[Mem_Addr];

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] e;
  } exp_t;

  exp_t sb[$];
  logic [31:0] held_d;
  logic [15:0] held_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] eff(input logic [15:0] b,
                                     input logic [7:0] o);
`ifdef WORD_LOADER_OFFSET_EN
    return b + {8'h00, o};
`else
    return b + 16'(0 * o);
`endif
  endfunction

  function automatic exp_t model(input logic [15:0] b,
                                 input logic [7:0] o);
    exp_t r;
    logic [15:0] a;
    a = eff(b, o);
    r.d = '0;
    for (int i = 0; i < NB; i++) begin
      r.d[8*i +: 8] = mem[a];
      a = a + 16'd1;
    end
    r.e = a;
    return r;
  endfunction

  // Global monitor: write strobe, idle CS, result hold and scoreboard.
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("mem_wr", Mem_WR, 0);
      if (!Busy) chk("cs_idle", Mem_CS, 1);
      if (Done) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("dataout", DataOut, e.d);
          chk("endaddr", EndAddr, e.e);
          held_d = e.d;
          held_e = e.e;
        end
      end else begin
        chk("hold_data", DataOut, held_d);
        chk("hold_end", EndAddr, held_e);
      end
    end
  end

  task automatic do_load(input logic [15:0] b, input logic [7:0] o);
    int n;
    logic [15:0] a;
    logic rd;
    @(negedge Clock);
    BaseAddr = b;
    Offset = o;
    Start = 1'b1;
    sb.push_back(model(b, o));
    a = eff(b, o);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
      if (n == 1) Start = 1'b0;
      rd = (n >= RS) && (n < RS + NB);
      chk("cs", Mem_CS, !rd);
      chk("busy", Busy, n < RS + NB);
      if (rd) chk("addr", Mem_Addr, 16'(a + 16'(n - RS)));
    end while (!Done && n < 20);
    chk("latency", n, LAT);
  endtask

  initial begin
    int dn [$];
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0040] = 8'h11; mem[16'h0041] = 8'h22;
    mem[16'h0042] = 8'h33; mem[16'h0043] = 8'h44;
    mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB;
    mem[16'h0000] = 8'hCC; mem[16'h0001] = 8'hDD;
    held_d = '0;
    held_e = '0;
    Reset = 1'b1;
    Start = 1'b0;
    BaseAddr = '0;
    Offset = '0;
    repeat (2) @(negedge Clock);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_cs", Mem_CS, 1);
    chk("rst_addr", Mem_Addr, 0);
    chk("rst_data", DataOut, 0);
    chk("rst_end", EndAddr, 0);
    Reset = 1'b0;

    do_load(16'h0040, 8'h00);
`ifndef WORD_LOADER_OFFSET_EN
    chk("t1_word", DataOut, 32'h44332211);
    chk("t1_end", EndAddr, 16'h0044);
`endif
    do_load(16'hFFFE, 8'h00);
`ifndef WORD_LOADER_OFFSET_EN
    chk("t2_word", DataOut, 32'hDDCCBBAA);
    chk("t2_end", EndAddr, 16'h0002);
`endif
    do_load(16'h0100, 8'h10);
    for (int i = 0; i < 4; i++)
      do_load(16'($urandom), 8'($urandom));

    // Start held for 10 cycles: DONE ignores it, IDLE re-accepts.
    @(negedge Clock);
    BaseAddr = 16'h0040;
    Offset = 8'h00;
    Start = 1'b1;
    sb.push_back(model(16'h0040, 8'h00));
    sb.push_back(model(16'h0040, 8'h00));
    n = 0;
    repeat (2 * LAT + 3) begin
      @(negedge Clock);
      n++;
      if (n == 10) Start = 1'b0;
      if (Done) dn.push_back(n);
      if (n <= 10) chk("t3_cs_busy", !Mem_CS && !Busy, 0);
    end
    chk("t3_ndone", dn.size(), 2);
    if (dn.size() == 2) begin
      chk("t3_done1", dn[0], LAT);
      chk("t3_done2", dn[1], 2 * LAT + 1);
    end

    // Reset in the 3rd READ cycle abandons the load.
    @(negedge Clock);
    BaseAddr = 16'h2000;
    Start = 1'b1;
    repeat (RS + 2) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    chk("t4_pre_cs", Mem_CS, 0);
    Reset = 1'b1;
    #1;
    chk("t4_busy", Busy, 0);
    chk("t4_cs", Mem_CS, 1);
    chk("t4_data", DataOut, 0);
    chk("t4_end", EndAddr, 0);
    held_d = '0;
    held_e = '0;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      chk("t4_nodone", Done, 0);
    end
    do_load(16'h0040, 8'h00);
    do_load(16'hFFFE, 8'h00);

    repeat (3) @(negedge Clock);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
